// File: rtl/fetch_unit_pkg.sv
// Shared instruction defines for the fetch path: opcode values, field positions
// and fetch FSM state encodings.
package fetch_unit_pkg;

    localparam int OPC_LSB = 16;
    localparam int OPC_W   = 8;
    localparam int OPD_LSB = 0;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_LDI = 8'h01;
    localparam logic [7:0] OP_LD  = 8'h02;
    localparam logic [7:0] OP_ST  = 8'h03;
    localparam logic [7:0] OP_ADD = 8'h04;
    localparam logic [7:0] OP_SUB = 8'h05;
    localparam logic [7:0] OP_JMP = 8'h10;
    localparam logic [7:0] OP_JMA = 8'h11;
    localparam logic [7:0] OP_CLL = 8'h12;
    localparam logic [7:0] OP_RET = 8'h13;
    localparam logic [7:0] OP_RST = 8'h14;

    typedef enum logic [1:0] {
        ST_FETCH    = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_ACU = 2'd2,
        ST_HALT     = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_call_stack.sv
// call_stack: circular LIFO of return addresses. The pointer wraps modulo DEPTH;
// the occupancy count saturates and drives full/empty.
module call_stack #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] sp;
    logic [PTR_W-1:0] sp_dec;
    logic [CNT_W-1:0] cnt;

    assign sp_dec = sp - 1'b1;
    assign dout   = mem[sp_dec];
    assign full   = (cnt == CNT_W'(DEPTH));
    assign empty  = (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sp  <= '0;
            cnt <= '0;
        end else if (push) begin
            sp <= sp + 1'b1;
            if (!full) cnt <= cnt + 1'b1;
        end else if (pop) begin
            sp <= sp_dec;
            if (!empty) cnt <= cnt - 1'b1;
        end
    end

    // Entries are data only; the pointer reset is enough to empty the stack.
    always_ff @(posedge clk) begin
        if (push && !rst) mem[sp] <= din;
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PLC-style instruction fetch with call stack and ACU-conditional jump.
// Define FETCH_STACK_CHECK_EN to halt with err_ovf/err_unf on stack misuse.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int WORD_WIDTH  = 24,
    parameter int ADDR_BITS   = 8,
    parameter int STACK_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_BITS-1:0]  rom_addr,
    input  logic [WORD_WIDTH-1:0] rom_data,
    output logic [WORD_WIDTH-1:0] instr,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  acu_valid,
    input  logic                  acu_nz,
    output logic                  err_ovf,
    output logic                  err_unf
);

`ifdef FETCH_STACK_CHECK_EN
    localparam bit STACK_CHECK = 1'b1;
`else
    localparam bit STACK_CHECK = 1'b0;
`endif

    fetch_state_t          state, state_nx;
    logic [ADDR_BITS-1:0]  pc, pc_nx, pc_inc, target;
    logic [WORD_WIDTH-1:0] instr_nx;
    logic                  vld_nx;
    logic [OPC_W-1:0]      opcode;
    logic                  push, pop, clr;
    logic                  ovf_hit, unf_hit;
    logic [ADDR_BITS-1:0]  stk_dout;
    logic                  stk_full, stk_empty;

    assign rom_addr = pc;
    assign opcode   = rom_data[OPC_LSB +: OPC_W];
    assign target   = rom_data[OPD_LSB +: ADDR_BITS];
    assign pc_inc   = pc + 1'b1;

    call_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (ADDR_BITS)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .dout  (stk_dout),
        .full  (stk_full),
        .empty (stk_empty)
    );

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        instr_nx = instr;
        vld_nx   = instr_valid;
        push     = 1'b0;
        pop      = 1'b0;
        clr      = 1'b0;
        ovf_hit  = 1'b0;
        unf_hit  = 1'b0;
        case (state)
            ST_FETCH: begin
                case (opcode)
                    OP_NOP: pc_nx = pc_inc;
                    OP_JMP: pc_nx = target;
                    OP_CLL: begin
                        if (STACK_CHECK && stk_full) begin
                            ovf_hit  = 1'b1;
                            state_nx = ST_HALT;
                        end else begin
                            push  = 1'b1;
                            pc_nx = target;
                        end
                    end
                    OP_RET: begin
                        if (STACK_CHECK && stk_empty) begin
                            unf_hit  = 1'b1;
                            state_nx = ST_HALT;
                        end else begin
                            pop   = 1'b1;
                            pc_nx = stk_dout;
                        end
                    end
                    OP_RST: begin
                        pc_nx = '0;
                        clr   = 1'b1;
                    end
                    // pc stays on the JMA word so its target remains on rom_data.
                    OP_JMA: state_nx = ST_WAIT_ACU;
                    default: begin
                        instr_nx = rom_data;
                        vld_nx   = 1'b1;
                        pc_nx    = pc_inc;
                        state_nx = ST_ISSUE;
                    end
                endcase
            end
            ST_ISSUE: begin
                if (instr_ready) begin
                    vld_nx   = 1'b0;
                    state_nx = ST_FETCH;
                end
            end
            ST_WAIT_ACU: begin
                if (acu_valid) begin
                    pc_nx    = acu_nz ? target : pc_inc;
                    state_nx = ST_FETCH;
                end
            end
            ST_HALT: state_nx = ST_HALT;
            default: state_nx = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_FETCH;
            pc          <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            instr       <= instr_nx;
            instr_valid <= vld_nx;
        end
    end

`ifdef FETCH_STACK_CHECK_EN
    logic ovf_q, unf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_q | ovf_hit;
            unf_q <= unf_q | unf_hit;
        end
    end

    assign err_ovf = ovf_q;
    assign err_unf = unf_q;
`else
    // Both hits are gated by STACK_CHECK and therefore constant zero here.
    assign err_ovf = ovf_hit;
    assign err_unf = unf_hit;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized ROM and
// handshake stimulus against an instruction-level reference model.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int WW = 24;
    localparam int AB = 8;
    localparam int SD = 8;

`ifdef FETCH_STACK_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [AB-1:0] rom_addr;
    logic [WW-1:0] rom_data;
    logic [WW-1:0] instr;
    logic          instr_valid;
    logic          instr_ready;
    logic          acu_valid;
    logic          acu_nz;
    logic          err_ovf;
    logic          err_unf;

    logic [WW-1:0] rom [256];
    assign rom_data = rom[rom_addr];

    always #5 clk = ~clk;

    fetch_unit #(
        .WORD_WIDTH  (WW),
        .ADDR_BITS   (AB),
        .STACK_DEPTH (SD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .acu_valid   (acu_valid),
        .acu_nz      (acu_nz),
        .err_ovf     (err_ovf),
        .err_unf     (err_unf)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: program-level view of the fetch unit.
    int          m_pc, m_sp, m_cnt;
    int          m_stk [SD];
    logic        m_pend, m_wait, m_halt, m_ovf, m_unf;
    logic [23:0] m_instr;
    logic [23:0] issued [$];

    function automatic logic [23:0] w(input logic [7:0] op, input int opd);
        return {op, 16'(opd)};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = w(OP_JMP, i);
    endtask

    task automatic model_tick();
        logic [23:0] wd;
        logic [7:0]  op;
        int          tgt;
        wd  = rom[m_pc];
        op  = wd[23:16];
        tgt = int'(wd[7:0]);
        if (rst) begin
            m_pc = 0; m_sp = 0; m_cnt = 0;
            m_pend = 1'b0; m_wait = 1'b0; m_halt = 1'b0;
            m_ovf = 1'b0; m_unf = 1'b0; m_instr = '0;
        end else if (m_halt) begin
            m_halt = 1'b1;
        end else if (m_pend) begin
            if (instr_ready) m_pend = 1'b0;
        end else if (m_wait) begin
            if (acu_valid) begin
                m_pc   = acu_nz ? tgt : (m_pc + 1) % 256;
                m_wait = 1'b0;
            end
        end else if (op == OP_NOP) begin
            m_pc = (m_pc + 1) % 256;
        end else if (op == OP_JMP) begin
            m_pc = tgt;
        end else if (op == OP_CLL) begin
            if (CHK && m_cnt == SD) begin
                m_halt = 1'b1; m_ovf = 1'b1;
            end else begin
                m_stk[m_sp] = (m_pc + 1) % 256;
                m_sp  = (m_sp + 1) % SD;
                m_cnt = (m_cnt < SD) ? m_cnt + 1 : SD;
                m_pc  = tgt;
            end
        end else if (op == OP_RET) begin
            if (CHK && m_cnt == 0) begin
                m_halt = 1'b1; m_unf = 1'b1;
            end else begin
                m_sp  = (m_sp + SD - 1) % SD;
                m_pc  = m_stk[m_sp];
                m_cnt = (m_cnt > 0) ? m_cnt - 1 : 0;
            end
        end else if (op == OP_RST) begin
            m_pc = 0; m_sp = 0; m_cnt = 0;
        end else if (op == OP_JMA) begin
            m_wait = 1'b1;
        end else begin
            m_instr = wd;
            m_pend  = 1'b1;
            m_pc    = (m_pc + 1) % 256;
        end
    endtask

    task automatic check_model();
        check_eq("rom_addr", rom_addr, m_pc);
        check_eq("instr_valid", instr_valid, m_pend);
        check_eq("instr", instr, m_instr);
        check_eq("err_ovf", err_ovf, m_ovf);
        check_eq("err_unf", err_unf, m_unf);
    endtask

    task automatic step();
        if (instr_valid === 1'b1 && instr_ready && !rst) issued.push_back(instr);
        @(posedge clk);
        model_tick();
        #1;
        check_model();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        issued.delete();
    endtask

    task automatic check_issued(input string tag, input int idx, input logic [23:0] exp);
        logic [23:0] got;
        got = (issued.size() > idx) ? issued[idx] : 24'hxxxxxx;
        check_eq(tag, got, exp);
    endtask

    initial begin
        rst = 1'b1; instr_ready = 1'b0; acu_valid = 1'b0; acu_nz = 1'b0;
        m_pc = 0; m_sp = 0; m_cnt = 0; m_instr = '0;
        m_pend = 1'b0; m_wait = 1'b0; m_halt = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        foreach (m_stk[i]) m_stk[i] = 0;
        clear_rom();

        step();
        check_eq("reset_pc", rom_addr, 0);
        check_eq("reset_vld", instr_valid, 0);
        check_eq("reset_instr", instr, 0);
        check_eq("reset_ovf", err_ovf, 0);
        check_eq("reset_unf", err_unf, 0);
        rst = 1'b0;

        // Scenario 1: NOP skipped, LDI and ST issued
        clear_rom();
        rom[0] = w(OP_NOP, 0); rom[1] = w(OP_LDI, 5); rom[2] = w(OP_ST, 1);
        instr_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 8; i++) step();
        check_eq("s1_count", issued.size(), 2);
        check_issued("s1_first", 0, w(OP_LDI, 5));
        check_issued("s1_second", 1, w(OP_ST, 1));
        check_eq("s1_pc_end", rom_addr, 3);

        // Scenario 2: call and return
        clear_rom();
        rom[0] = w(OP_NOP, 0); rom[1] = w(OP_CLL, 20); rom[2] = w(OP_LD, 2);
        rom[20] = w(OP_LDI, 5); rom[21] = w(OP_RET, 0);
        do_reset();
        for (int i = 0; i < 10; i++) step();
        check_eq("s2_count", issued.size(), 2);
        check_issued("s2_first", 0, w(OP_LDI, 5));
        check_issued("s2_second", 1, w(OP_LD, 2));
        check_eq("s2_stack_empty", dut.u_stack.empty, 1);

        // Scenario 3: JMA taken and not taken
        clear_rom();
        rom[0] = w(OP_JMP, 14); rom[14] = w(OP_JMA, 8);
        do_reset();
        step(); step();
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("s3_wait_pc", rom_addr, 14);
        end
        acu_valid = 1'b1; acu_nz = 1'b1;
        step();
        check_eq("s3_taken_pc", rom_addr, 8);
        acu_valid = 1'b0;
        do_reset();
        step(); step(); step();
        acu_valid = 1'b1; acu_nz = 1'b0;
        step();
        check_eq("s3_fall_pc", rom_addr, 15);
        acu_valid = 1'b0;

        // Scenario 4: stall in ISSUE, then reset discards the held instruction
        clear_rom();
        rom[0] = w(OP_LDI, 7);
        instr_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("s4_hold_instr", instr, w(OP_LDI, 7));
            check_eq("s4_hold_vld", instr_valid, 1);
            check_eq("s4_hold_pc", rom_addr, 1);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("s4_rst_vld", instr_valid, 0);
        check_eq("s4_rst_pc", rom_addr, 0);
        instr_ready = 1'b1;

        // Scenario 5: nine nested calls
        clear_rom();
        for (int k = 0; k < 9; k++) begin
            rom[10 * k]     = w(OP_CLL, 10 * (k + 1));
            rom[10 * k + 1] = w(OP_RET, 0);
        end
        rom[90] = w(OP_RET, 0);
        do_reset();
`ifdef FETCH_STACK_CHECK_EN
        for (int i = 0; i < 8; i++) step();
        check_eq("s5_pc_before_ovf", rom_addr, 80);
        step();
        check_eq("s5_ovf", err_ovf, 1);
        for (int i = 0; i < 3; i++) step();
        check_eq("s5_halt_pc", rom_addr, 80);
        check_eq("s5_halt_issued", issued.size(), 0);
        check_eq("s5_halt_ovf", err_ovf, 1);
        do_reset();
        check_eq("s5_ovf_cleared", err_ovf, 0);
        clear_rom();
        rom[0] = w(OP_RET, 0);
        do_reset();
        step();
        check_eq("s5_unf", err_unf, 1);
        step(); step();
        check_eq("s5_unf_pc", rom_addr, 0);
`else
        for (int i = 0; i < 9; i++) step();
        check_eq("s5_pc_after_calls", rom_addr, 90);
        check_eq("s5_no_ovf", err_ovf, 0);
        step();
        check_eq("s5_ret1", rom_addr, 81);
        for (int i = 0; i < 7; i++) step();
        check_eq("s5_ret8", rom_addr, 11);
        step();
        check_eq("s5_ret9", rom_addr, 81);
        check_eq("s5_no_unf", err_unf, 0);
`endif

        // Scenario 6: pc wrap and RST word
        clear_rom();
        rom[0] = w(OP_JMP, 255); rom[255] = w(OP_LDI, 9);
        instr_ready = 1'b0;
        do_reset();
        step();
        check_eq("s6_pc_255", rom_addr, 255);
        step();
        check_eq("s6_wrap_pc", rom_addr, 0);
        check_eq("s6_wrap_instr", instr, w(OP_LDI, 9));
        instr_ready = 1'b1;
        clear_rom();
        rom[0] = w(OP_CLL, 5); rom[5] = w(OP_RST, 0);
        do_reset();
        step();
        check_eq("s6_sp_pushed", dut.u_stack.sp, 1);
        step();
        check_eq("s6_rst_pc", rom_addr, 0);
        check_eq("s6_rst_sp", dut.u_stack.sp, 0);

        // Randomized programs and handshakes
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 256; i++) begin
                int sel;
                logic [7:0] op;
                sel = $urandom_range(0, 11);
                case (sel)
                    0: op = OP_NOP;
                    1: op = OP_JMP;
                    2: op = OP_CLL;
                    3: op = OP_RET;
                    4: op = OP_JMA;
                    5: op = OP_RST;
                    6: op = OP_LDI;
                    7: op = OP_ST;
                    default: op = 8'($urandom_range(0, 255));
                endcase
                rom[i] = {op, 16'($urandom_range(0, 65535))};
            end
            do_reset();
            for (int c = 0; c < 500; c++) begin
                instr_ready = ($urandom_range(0, 3) != 0);
                acu_valid   = ($urandom_range(0, 2) == 0);
                acu_nz      = 1'($urandom_range(0, 1));
                rst         = ($urandom_range(0, 99) == 0);
                step();
            end
            rst = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
